// File: rtl/sga_snake_engine.sv
// Snake game engine: circular-buffer body, serial self-collision check, serial LED render.
// Step and render each take length+1 cycles; step/render_start are ignored while busy, start aborts either.
module sga_snake_engine #(
   parameter int          GRID_W    = 3,
   parameter int          MAX_LEN   = 16,
   parameter int          WRAP      = 0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [3:0]                    buttons,
   input  logic                          step,
   input  logic                          render_start,
   output logic                          busy,
   output logic                          render_done,
   output logic                          ate,
   output logic                          collision,
   output logic [$clog2(MAX_LEN):0]      length,
   output logic [2*GRID_W-1:0]           head_pos,
   output logic [2*GRID_W-1:0]           apple_pos,
   output logic [(1 << (2*GRID_W))-1:0]  leds
);

   localparam int CW = 2 * GRID_W;
   localparam int PW = $clog2(MAX_LEN);
   localparam int LW = PW + 1;
   localparam int NL = 1 << CW;

   localparam logic [3:0] DIR_UP    = 4'b1000;
   localparam logic [3:0] DIR_DOWN  = 4'b0100;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0001;

   typedef enum logic [2:0] {IDLE, CHECK, MOVE, RENDER, COMMIT} state_t;

   state_t            state;
   logic [15:0]       lfsr;
   logic [CW-1:0]     body [MAX_LEN];
   logic [PW-1:0]     hp;
   logic [LW-1:0]     idx;
   logic [3:0]        dir;
   logic [CW-1:0]     nh;
   logic              hit;
   logic [NL-1:0]     shadow;

   logic [GRID_W-1:0] row, col, nrow, ncol;
   logic              off_grid, wall, btn_ok, grow, last;
   logic [PW-1:0]     seg_ptr;
   logic [CW-1:0]     seg;

   assign row = head_pos[CW-1:GRID_W];
   assign col = head_pos[GRID_W-1:0];

   always_comb begin
      nrow     = row;
      ncol     = col;
      off_grid = 1'b0;
      case (dir)
         DIR_UP: begin
            nrow     = row - GRID_W'(1);
            off_grid = (row == '0);
         end
         DIR_DOWN: begin
            nrow     = row + GRID_W'(1);
            off_grid = &row;
         end
         DIR_LEFT: begin
            ncol     = col - GRID_W'(1);
            off_grid = (col == '0);
         end
         default: begin
            ncol     = col + GRID_W'(1);
            off_grid = &col;
         end
      endcase
   end

   // GRID_W-bit arithmetic already wraps, so WRAP only decides whether leaving the grid is fatal.
   assign wall    = off_grid && (WRAP == 0);
   assign btn_ok  = (buttons != 4'b0000) &&
                    ((buttons & (buttons - 4'd1)) == 4'b0000) &&
                    (buttons != {dir[2], dir[3], dir[0], dir[1]});
   assign grow    = (nh == apple_pos);
   assign last    = (idx == length - LW'(1));
   assign seg_ptr = hp - idx[PW-1:0];
   assign seg     = body[seg_ptr];
   assign busy    = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         length      <= LW'(1);
         hp          <= '0;
         head_pos    <= '0;
         dir         <= DIR_RIGHT;
         collision   <= 1'b0;
         ate         <= 1'b0;
         render_done <= 1'b0;
         leds        <= '0;
         apple_pos   <= LFSR_SEED[CW-1:0];
         idx         <= '0;
         nh          <= '0;
         hit         <= 1'b0;
         shadow      <= '0;
         for (int i = 0; i < MAX_LEN; i++) begin
            body[i] <= '0;
         end
      end else begin
         ate         <= 1'b0;
         render_done <= 1'b0;
         if (start) begin
            state     <= IDLE;
            length    <= LW'(1);
            hp        <= '0;
            body[0]   <= '0;
            head_pos  <= '0;
            dir       <= DIR_RIGHT;
            collision <= 1'b0;
            apple_pos <= lfsr[CW-1:0];
            leds      <= '0;
            idx       <= '0;
            hit       <= 1'b0;
         end else begin
            if (btn_ok) begin
               dir <= buttons;
            end
            case (state)
               IDLE: begin
                  if (step && !collision) begin
                     nh    <= {nrow, ncol};
                     idx   <= '0;
                     hit   <= 1'b0;
                     state <= CHECK;
                     if (wall) begin
                        collision <= 1'b1;
                     end
                  end else if (render_start && !step) begin
                     shadow <= '0;
                     idx    <= '0;
                     state  <= RENDER;
                  end
               end
               CHECK: begin
                  // A wall hit already raised collision on entry; nothing left to scan.
                  if (collision) begin
                     state <= IDLE;
                  end else begin
                     // The tail moves away this step unless the snake grows into the apple.
                     if ((seg == nh) && (!last || grow)) begin
                        hit <= 1'b1;
                     end
                     idx <= idx + LW'(1);
                     if (last) begin
                        state <= MOVE;
                     end
                  end
               end
               MOVE: begin
                  if (hit) begin
                     collision <= 1'b1;
                  end else begin
                     hp                  <= hp + PW'(1);
                     body[hp + PW'(1)]   <= nh;
                     head_pos            <= nh;
                     if (grow) begin
                        ate       <= 1'b1;
                        apple_pos <= lfsr[CW-1:0];
                        if (length != LW'(MAX_LEN)) begin
                           length <= length + LW'(1);
                        end
                     end
                  end
                  state <= IDLE;
               end
               RENDER: begin
                  shadow[seg] <= 1'b1;
                  idx         <= idx + LW'(1);
                  if (last) begin
                     state <= COMMIT;
                  end
               end
               COMMIT: begin
                  leds        <= shadow | (NL'(1) << apple_pos);
                  render_done <= 1'b1;
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sga_snake_engine.sv
// Directed bench for sga_snake_engine: a WRAP=0 instance plus a WRAP=1 twin on shared stimulus.
// Apple placement is steered by timing start/step against a reference LFSR.
module tb_sga_snake_engine;

   localparam logic [3:0] BR = 4'b0001;
   localparam logic [3:0] BL = 4'b0010;
   localparam logic [3:0] BD = 4'b0100;
   localparam logic [3:0] BU = 4'b1000;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        step = 1'b0;
   logic        render_start = 1'b0;
   logic [3:0]  buttons = 4'b0000;

   logic        busy, render_done, ate, collision;
   logic [4:0]  length;
   logic [5:0]  head_pos, apple_pos;
   logic [63:0] leds;

   logic        w_busy, w_render_done, w_ate, w_collision;
   logic [4:0]  w_length;
   logic [5:0]  w_head_pos, w_apple_pos;
   logic [63:0] w_leds;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] lfsr_m = 16'hACE1;

   sga_snake_engine #(.GRID_W(3), .MAX_LEN(16), .WRAP(0), .LFSR_SEED(16'hACE1)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .buttons(buttons), .step(step),
      .render_start(render_start), .busy(busy), .render_done(render_done), .ate(ate),
      .collision(collision), .length(length), .head_pos(head_pos), .apple_pos(apple_pos),
      .leds(leds));

   sga_snake_engine #(.GRID_W(3), .MAX_LEN(16), .WRAP(1), .LFSR_SEED(16'hACE1)) dut_wrap (
      .clock(clock), .reset_n(reset_n), .start(start), .buttons(buttons), .step(step),
      .render_start(render_start), .busy(w_busy), .render_done(w_render_done), .ate(w_ate),
      .collision(w_collision), .length(w_length), .head_pos(w_head_pos), .apple_pos(w_apple_pos),
      .leds(w_leds));

   always #5 clock = ~clock;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
      logic [15:0] r;
      r = v;
      for (int k = 0; k < n; k++) r = lfsr_next(r);
      return r;
   endfunction

   // Reference generator: holds the seed in reset, then advances every rising edge.
   always @(posedge clock) begin
      if (!reset_n) lfsr_m = 16'hACE1;
      else          lfsr_m = lfsr_next(lfsr_m);
   end

   typedef struct {
      bit         is_start;
      logic [3:0] btn;
      bit         want_ate;
      logic [5:0] apple;
      logic [5:0] exp_head;
      logic [4:0] exp_len;
      bit         exp_coll;
      int         exp_busy;
      bit         chk_wrap;
   } vec_t;

   function automatic vec_t vs(input logic [5:0] a);
      vec_t v;
      v.is_start = 1'b1; v.btn = 4'b0; v.want_ate = 1'b0; v.apple = a;
      v.exp_head = 6'h00; v.exp_len = 5'd1; v.exp_coll = 1'b0; v.exp_busy = 0; v.chk_wrap = 1'b0;
      return v;
   endfunction

   function automatic vec_t vm(input logic [3:0] b, input bit a, input logic [5:0] ap,
                               input logic [5:0] h, input logic [4:0] l, input bit c, input int bz);
      vec_t v;
      v.is_start = 1'b0; v.btn = b; v.want_ate = a; v.apple = ap;
      v.exp_head = h; v.exp_len = l; v.exp_coll = c; v.exp_busy = bz; v.chk_wrap = 1'b0;
      return v;
   endfunction

   function automatic vec_t vw(input logic [3:0] b, input logic [5:0] h, input bit c, input int bz);
      vec_t v;
      v = vm(b, 1'b0, 6'h00, h, 5'd1, c, bz);
      v.chk_wrap = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bad(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic do_start(input logic [5:0] tgt);
      bit found;
      found = 1'b0;
      buttons = 4'b0000;
      for (int n = 0; n < 4000 && !found; n++) begin
         @(negedge clock);
         if (lfsr_m[5:0] == tgt) found = 1'b1;
      end
      if (!found) begin
         bad("start_apple_search");
         return;
      end
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("start_busy", busy, 0);
      chk("start_head", head_pos, 6'h00);
      chk("start_len", length, 5'd1);
      chk("start_coll", collision, 0);
      chk("start_apple", apple_pos, tgt);
      chk("start_leds", leds, 64'h0);
   endtask

   task automatic do_step(input logic [3:0] btn, input bit want_ate, input logic [5:0] tgt,
                          input logic [5:0] exp_head, input logic [4:0] exp_len, input bit exp_coll,
                          input int exp_busy, input int cur_len, input bit chk_wrap);
      bit          found;
      int          cnt;
      logic [15:0] fut;
      buttons = btn;
      @(negedge clock);
      found = !want_ate;
      for (int n = 0; n < 4000 && !found; n++) begin
         fut = lfsr_adv(lfsr_m, cur_len + 1);
         if (fut[5:0] == tgt) found = 1'b1;
         else @(negedge clock);
      end
      if (!found) begin
         bad("step_apple_search");
         return;
      end
      step = 1'b1;
      @(negedge clock);
      step = 1'b0;
      cnt = 0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clock);
      end
      chk("busy_cycles", cnt, exp_busy);
      chk("head_pos", head_pos, exp_head);
      chk("length", length, exp_len);
      chk("collision", collision, exp_coll);
      chk("ate_pulse", ate, want_ate);
      if (want_ate) chk("apple_reload", apple_pos, tgt);
      @(negedge clock);
      chk("ate_low_after", ate, 0);
      if (chk_wrap) begin
         chk("wrap_head", w_head_pos, 6'h00);
         chk("wrap_coll", w_collision, 0);
         chk("wrap_busy", w_busy, 0);
         chk("wrap_len", w_length, 5'd1);
         chk("wrap_apple", w_apple_pos, 6'h3F);
         chk("wrap_ate", w_ate, 0);
         chk("wrap_rdone", w_render_done, 0);
         chk("wrap_leds", w_leds, 64'h0);
      end
   endtask

   function automatic logic [5:0] path_next(input logic [5:0] p);
      logic [2:0] r, c;
      r = p[5:3];
      c = p[2:0];
      if (r == 3'd0)      return (c < 3'd7) ? {r, c + 3'd1} : {r + 3'd1, c};
      else if (c == 3'd0) return {r - 3'd1, c};
      else if (r[0])      return (c > 3'd1 || r == 3'd7) ? {r, c - 3'd1} : {r + 3'd1, c};
      else                return (c < 3'd7) ? {r, c + 3'd1} : {r + 3'd1, c};
   endfunction

   function automatic logic [3:0] dir_to(input logic [5:0] a, input logic [5:0] b);
      if (b[5:3] < a[5:3]) return BU;
      if (b[5:3] > a[5:3]) return BD;
      if (b[2:0] < a[2:0]) return BL;
      return BR;
   endfunction

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end

   initial begin
      vec_t       tbl[$];
      int         cur_len;
      int         cnt;
      bit         seen;
      logic [5:0] path [18];
      logic [5:0] exp_apple;

      // Wall / wrap, steering rules, single eat, self-collision loop, tail-vacate loop, render setup.
      tbl.push_back(vs(6'h3F));
      for (int i = 1; i <= 7; i++) tbl.push_back(vm(BR, 0, 0, 6'(i), 5'd1, 0, 2));
      tbl.push_back(vw(BR, 6'h07, 1, 1));
      tbl.push_back(vm(BR, 0, 0, 6'h07, 5'd1, 1, 0));
      tbl.push_back(vs(6'h3F));
      tbl.push_back(vm(BL,      0, 0, 6'h01, 5'd1, 0, 2));
      tbl.push_back(vm(4'b0101, 0, 0, 6'h02, 5'd1, 0, 2));
      tbl.push_back(vm(BD,      0, 0, 6'h0A, 5'd1, 0, 2));
      tbl.push_back(vs(6'h01));
      tbl.push_back(vm(BR, 1, 6'h3F, 6'h01, 5'd2, 0, 2));
      tbl.push_back(vs(6'h01));
      tbl.push_back(vm(BR, 1, 6'h02, 6'h01, 5'd2, 0, 2));
      tbl.push_back(vm(BR, 1, 6'h03, 6'h02, 5'd3, 0, 3));
      tbl.push_back(vm(BR, 1, 6'h04, 6'h03, 5'd4, 0, 4));
      tbl.push_back(vm(BR, 1, 6'h3F, 6'h04, 5'd5, 0, 5));
      tbl.push_back(vm(BD, 0, 0,     6'h0C, 5'd5, 0, 6));
      tbl.push_back(vm(BL, 0, 0,     6'h0B, 5'd5, 0, 6));
      tbl.push_back(vm(BU, 0, 0,     6'h0B, 5'd5, 1, 6));
      tbl.push_back(vs(6'h01));
      tbl.push_back(vm(BR, 1, 6'h02, 6'h01, 5'd2, 0, 2));
      tbl.push_back(vm(BR, 1, 6'h03, 6'h02, 5'd3, 0, 3));
      tbl.push_back(vm(BR, 1, 6'h3F, 6'h03, 5'd4, 0, 4));
      tbl.push_back(vm(BD, 0, 0,     6'h0B, 5'd4, 0, 5));
      tbl.push_back(vm(BL, 0, 0,     6'h0A, 5'd4, 0, 5));
      tbl.push_back(vm(BU, 0, 0,     6'h02, 5'd4, 0, 5));
      tbl.push_back(vs(6'h01));
      tbl.push_back(vm(BR, 1, 6'h02, 6'h01, 5'd2, 0, 2));
      tbl.push_back(vm(BR, 1, 6'h15, 6'h02, 5'd3, 0, 3));

      // Reset state, then the first step from (0,0).
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_len", length, 5'd1);
      chk("rst_head", head_pos, 6'h00);
      chk("rst_coll", collision, 0);
      chk("rst_ate", ate, 0);
      chk("rst_rdone", render_done, 0);
      chk("rst_leds", leds, 64'h0);
      chk("rst_apple", apple_pos, 6'h21);
      reset_n = 1'b1;
      do_step(BR, 0, 6'h00, 6'h01, 5'd1, 0, 2, 1, 0);

      cur_len = 1;
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].is_start) begin
            do_start(tbl[i].apple);
            cur_len = 1;
         end else begin
            do_step(tbl[i].btn, tbl[i].want_ate, tbl[i].apple, tbl[i].exp_head, tbl[i].exp_len,
                    tbl[i].exp_coll, tbl[i].exp_busy, cur_len, tbl[i].chk_wrap);
            cur_len = int'(tbl[i].exp_len);
         end
      end

      // Render of body (0,2),(0,1),(0,0) with apple at (2,5).
      buttons = 4'b0000;
      @(negedge clock);
      render_start = 1'b1;
      @(negedge clock);
      render_start = 1'b0;
      cnt = 0;
      while (!render_done && cnt < 50) begin
         chk("leds_hold", leds, 64'h0);
         cnt++;
         @(negedge clock);
      end
      chk("render_latency", cnt, 4);
      chk("render_leds", leds, 64'h0000_0000_0020_0007);
      chk("render_busy", busy, 0);
      @(negedge clock);
      chk("render_done_end", render_done, 0);

      // step and render_start together: the step wins, no render happens.
      buttons = BR;
      @(negedge clock);
      step = 1'b1;
      render_start = 1'b1;
      @(negedge clock);
      step = 1'b0;
      render_start = 1'b0;
      cnt = 0;
      seen = 1'b0;
      while (busy && cnt < 100) begin
         cnt++;
         @(negedge clock);
      end
      chk("dual_busy", cnt, 4);
      chk("dual_head", head_pos, 6'h03);
      for (int n = 0; n < 8; n++) begin
         if (render_done) seen = 1'b1;
         @(negedge clock);
      end
      chk("dual_no_render", seen, 0);
      chk("dual_leds", leds, 64'h0000_0000_0020_0007);

      // start in the middle of a render aborts it silently.
      buttons = 4'b0000;
      render_start = 1'b1;
      @(negedge clock);
      render_start = 1'b0;
      @(negedge clock);
      chk("midr_busy", busy, 1);
      exp_apple = lfsr_m[5:0];
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("midr_idle", busy, 0);
      chk("midr_len", length, 5'd1);
      chk("midr_head", head_pos, 6'h00);
      chk("midr_leds", leds, 64'h0);
      chk("midr_apple", apple_pos, exp_apple);
      seen = render_done;
      for (int n = 0; n < 6; n++) begin
         @(negedge clock);
         if (render_done || busy) seen = 1'b1;
      end
      chk("midr_no_done", seen, 0);

      // Grow to 16 along a serpentine path, then eat once more at full length.
      path[0] = 6'h00;
      for (int k = 1; k < 18; k++) path[k] = path_next(path[k-1]);
      do_start(path[1]);
      cur_len = 1;
      for (int k = 1; k <= 16; k++) begin
         do_step(dir_to(path[k-1], path[k]), 1, path[k+1], path[k],
                 5'((k + 1 > 16) ? 16 : k + 1), 0, cur_len + 1, cur_len, 0);
         cur_len = (k + 1 > 16) ? 16 : k + 1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
